// File: rtl/ddr_pkg.sv
// Shared types for the DDR command scheduler: command encoding, FSM states, beat-counter width.
package ddr_pkg;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_TRCD_WAIT,
    S_RW,
    S_BURST,
    S_PRE,
    S_TRP_WAIT
  } sched_state_t;

  // Index of the final beat, N-1, for a burst of N = 1 << size beats.
  function automatic logic [BEAT_CNT_W-1:0] burst_last_idx(input logic [1:0] size);
    logic [BEAT_CNT_W-1:0] one;
    one = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
    return (one << size) - one;
  endfunction

endpackage

// File: rtl/ddr_delay_counter.sv
// Loadable down-counter timing the TRCD and TRP waits; holds at zero once expired.
module ddr_delay_counter
  import ddr_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_load,
  input  logic [BEAT_CNT_W-1:0] i_load_val,
  output logic [BEAT_CNT_W-1:0] o_value,
  output logic                  o_done
);

  logic [BEAT_CNT_W-1:0] r_value;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - BEAT_CNT_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_done  = (r_value == '0);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Single-bank DDR scheduler: host request -> ACT / RD|WR / beats / PRE, all outputs registered.
// Define DDR_OPEN_ROW_EN for the open-page policy; the default build closes the row after every burst.
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int ROW_W = 14,
  parameter int COL_W = 10,
  parameter int TRCD  = 3,
  parameter int TRP   = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       burst_size,
  input  logic             config_update,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             req_ready,
  output logic [2:0]       cmd,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic             beat_valid,
  output logic             beat_last,
  output logic             busy
);

  // The counter is loaded in ACT/PRE, so the wait states see TRCD-1 / TRP-1 cycles.
  localparam logic [BEAT_CNT_W-1:0] TRCD_LD = (TRCD > 1) ? BEAT_CNT_W'(TRCD - 2) : '0;
  localparam logic [BEAT_CNT_W-1:0] TRP_LD  = (TRP > 1)  ? BEAT_CNT_W'(TRP - 2)  : '0;

  sched_state_t          r_state, w_state_next;
  logic                  r_write;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [BEAT_CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
  cmd_t                  r_cmd, w_cmd_next;
  logic [ROW_W-1:0]      r_cmd_row, w_cmd_row_next;
  logic [COL_W-1:0]      r_cmd_col, w_cmd_col_next;
  logic                  r_beat_valid, r_beat_last, r_busy;
  logic                  w_accept, w_write_cur;
  logic [ROW_W-1:0]      w_row_cur;
  logic [COL_W-1:0]      w_col_cur;
  logic                  w_dly_load, w_dly_done;
  logic [BEAT_CNT_W-1:0] w_dly_load_val, w_dly_value_unused;
  logic                  w_row_open, w_row_hit, w_close_now, w_pending;

  assign req_ready = (r_state == S_IDLE) && !config_update;
  assign w_accept  = req_valid && req_ready;

  // On the accept cycle the host fields are not yet latched, so forward them.
  assign w_write_cur = w_accept ? req_write : r_write;
  assign w_row_cur   = w_accept ? req_row   : r_row;
  assign w_col_cur   = w_accept ? req_col   : r_col;

`ifdef DDR_OPEN_ROW_EN
  localparam bit OPEN_PAGE = 1'b1;
  logic r_row_open, r_close_req, r_pending;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_row_open  <= 1'b0;
      r_close_req <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_state_next == S_PRE) begin
        r_row_open  <= 1'b0;
        r_close_req <= 1'b0;
      end else begin
        if (r_state == S_BURST && w_state_next == S_IDLE) r_row_open <= 1'b1;
        if (config_update && (r_row_open || r_state inside {S_ACT, S_TRCD_WAIT, S_RW, S_BURST}))
          r_close_req <= 1'b1;
      end
      // A miss on an open row parks the request until the row is precharged.
      if (w_accept) r_pending <= r_row_open && !w_row_hit;
      else if (w_state_next == S_ACT) r_pending <= 1'b0;
    end
  end

  assign w_row_open  = r_row_open;
  assign w_row_hit   = r_row_open && !r_close_req && (req_row == r_row);
  assign w_close_now = r_row_open && (r_close_req || config_update);
  assign w_pending   = r_pending;
`else
  localparam bit OPEN_PAGE = 1'b0;
  assign w_row_open  = 1'b0;
  assign w_row_hit   = 1'b0;
  assign w_close_now = 1'b0;
  assign w_pending   = 1'b0;
`endif

  assign w_dly_load     = (r_state == S_ACT) || (r_state == S_PRE);
  assign w_dly_load_val = (r_state == S_ACT) ? TRCD_LD : TRP_LD;

  ddr_delay_counter u_delay (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_load_val),
    .o_value    (w_dly_value_unused),
    .o_done     (w_dly_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_row_hit)       w_state_next = S_RW;
          else if (w_row_open) w_state_next = S_PRE;
          else                 w_state_next = S_ACT;
        end else if (w_close_now) begin
          w_state_next = S_PRE;
        end
      end
      S_ACT:       w_state_next = (TRCD > 1) ? S_TRCD_WAIT : S_RW;
      S_TRCD_WAIT: if (w_dly_done) w_state_next = S_RW;
      S_RW:        w_state_next = S_BURST;
      S_BURST:     if (r_beat_cnt == '0) w_state_next = OPEN_PAGE ? S_IDLE : S_PRE;
      S_PRE:       w_state_next = (TRP > 1) ? S_TRP_WAIT : (w_pending ? S_ACT : S_IDLE);
      S_TRP_WAIT:  if (w_dly_done) w_state_next = w_pending ? S_ACT : S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_write    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_row   <= req_row;
        r_col   <= req_col;
      end
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_beat_cnt_next = r_beat_cnt;
    if (w_accept)                w_beat_cnt_next = burst_last_idx(burst_size);
    else if (r_state == S_BURST) w_beat_cnt_next = r_beat_cnt - BEAT_CNT_W'(1);
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_cmd_next     = CMD_NOP;
    w_cmd_row_next = '0;
    w_cmd_col_next = '0;
    case (w_state_next)
      S_ACT: begin
        w_cmd_next     = CMD_ACT;
        w_cmd_row_next = w_row_cur;
      end
      S_RW: begin
        w_cmd_next     = w_write_cur ? CMD_WR : CMD_RD;
        w_cmd_col_next = w_col_cur;
      end
      S_PRE:   w_cmd_next = CMD_PRE;
      default: w_cmd_next = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cmd        <= CMD_NOP;
      r_cmd_row    <= '0;
      r_cmd_col    <= '0;
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cmd        <= w_cmd_next;
      r_cmd_row    <= w_cmd_row_next;
      r_cmd_col    <= w_cmd_col_next;
      r_beat_valid <= (w_state_next == S_BURST);
      r_beat_last  <= (w_state_next == S_BURST) && (w_beat_cnt_next == '0);
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  assign cmd        = r_cmd;
  assign cmd_row    = r_cmd_row;
  assign cmd_col    = r_cmd_col;
  assign beat_valid = r_beat_valid;
  assign beat_last  = r_beat_last;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: expected command/beat events are queued at accept and
// compared cycle by cycle; every cycle with no queued event must show idle outputs.
module tb_ddr_cmd_scheduler;
  import ddr_pkg::*;

  localparam int ROW_W = 14;
  localparam int COL_W = 10;
  localparam int TRCD  = 3;
  localparam int TRP   = 3;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic [1:0]       burst_size = 2'd2;
  logic             config_update = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_write = 1'b0;
  logic [ROW_W-1:0] req_row = '0;
  logic [COL_W-1:0] req_col = '0;
  logic             req_ready;
  logic [2:0]       cmd;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             beat_valid, beat_last, busy;

  always #5 clk = ~clk;

  ddr_cmd_scheduler #(.ROW_W(ROW_W), .COL_W(COL_W), .TRCD(TRCD), .TRP(TRP)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .burst_size    (burst_size),
    .config_update (config_update),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_row       (req_row),
    .req_col       (req_col),
    .req_ready     (req_ready),
    .cmd           (cmd),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .beat_valid    (beat_valid),
    .beat_last     (beat_last),
    .busy          (busy)
  );

  typedef struct {
    int               cyc;
    logic [2:0]       cmd;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             bv;
    logic             bl;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  busy_lo = 0;
  int  busy_hi = -1;
  int  acc_cyc = 0;
  bit  accepted = 1'b0;
`ifdef DDR_OPEN_ROW_EN
  bit               m_open = 1'b0;
  logic [ROW_W-1:0] m_row = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] k, input logic [ROW_W-1:0] r,
                      input logic [COL_W-1:0] cl, input logic bv, input logic bl);
    ev_t e;
    e.cyc = c; e.cmd = k; e.row = r; e.col = cl; e.bv = bv; e.bl = bl;
    q.push_back(e);
  endtask

  // Reference timing: accept in cycle acc, events relative to it.
  task automatic model_accept(input int acc);
    int t, n;
    n = 1 << burst_size;
    t = acc + 1;
`ifdef DDR_OPEN_ROW_EN
    if (m_open && m_row != req_row) begin
      push(t, CMD_PRE, '0, '0, 1'b0, 1'b0);
      t += TRP;
    end
    if (!(m_open && m_row == req_row)) begin
      push(t, CMD_ACT, req_row, '0, 1'b0, 1'b0);
      t += TRCD;
    end
`else
    push(t, CMD_ACT, req_row, '0, 1'b0, 1'b0);
    t += TRCD;
`endif
    push(t, req_write ? CMD_WR : CMD_RD, '0, req_col, 1'b0, 1'b0);
    t++;
    for (int i = 0; i < n; i++) push(t + i, CMD_NOP, '0, '0, 1'b1, (i == n - 1));
    t += n;
`ifdef DDR_OPEN_ROW_EN
    m_open = 1'b1;
    m_row  = req_row;
`else
    push(t, CMD_PRE, '0, '0, 1'b0, 1'b0);
    t += TRP;
`endif
    busy_lo = acc + 1;
    busy_hi = t - 1;
  endtask

  // Check the current cycle's outputs, apply the model for this cycle's inputs, advance one cycle.
  task automatic step();
    ev_t e;
    bit  exp_busy, exp_rdy;
    #1;
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    exp_rdy  = !exp_busy && !config_update;
    e.cyc = cyc; e.cmd = CMD_NOP; e.row = '0; e.col = '0; e.bv = 1'b0; e.bl = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
    chk("cmd", cmd, e.cmd);
    chk("cmd_row", cmd_row, e.row);
    chk("cmd_col", cmd_col, e.col);
    chk("beat_valid", beat_valid, e.bv);
    chk("beat_last", beat_last, e.bl);
    chk("busy", busy, exp_busy);
    chk("req_ready", req_ready, exp_rdy);
    accepted = 1'b0;
`ifdef DDR_OPEN_ROW_EN
    if (n_rst && config_update && m_open && !exp_busy) begin
      push(cyc + 1, CMD_PRE, '0, '0, 1'b0, 1'b0);
      busy_lo = cyc + 1;
      busy_hi = cyc + TRP;
      m_open  = 1'b0;
    end
`endif
    if (n_rst && req_valid && exp_rdy) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
      model_accept(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic request(input bit w, input int row, input int col);
    req_valid = 1'b1;
    req_write = w;
    req_row   = ROW_W'(row);
    req_col   = COL_W'(col);
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) step();
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    // Scramble the fields after accept; they must not leak into the transaction.
    req_valid = 1'b0;
    req_write = ~w;
    req_row   = ROW_W'($urandom);
    req_col   = COL_W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q.size() > 0 || cyc <= busy_hi); i++) step();
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    step();
    step();
    n_rst = 1'b1;
    cyc = 0;

    // Read row 5 col 8, N=4: ACT@1 RD@4 beats 5..8 PRE@9 ready@12.
    burst_size = 2'd2;
    request(1'b0, 5, 8);
    repeat (3) step();
    drain();

    // Single-beat write, then a back-to-back read whose burst size changes mid-burst.
    burst_size = 2'd0;
    request(1'b1, 100, 3);
    burst_size = 2'd2;
    request(1'b0, 20, 40);
    while (cyc < acc_cyc + TRCD + 3) step();
    burst_size = 2'd3;
    request(1'b0, 21, 41);
    drain();

    // config_update in IDLE with a request waiting: refused that cycle, new size used.
    step();
    req_valid = 1'b1; req_write = 1'b0; req_row = ROW_W'(30); req_col = COL_W'(60);
    config_update = 1'b1;
    burst_size = 2'd1;
    step();
    config_update = 1'b0;
    request(1'b0, 30, 60);
    drain();

    // Two reads to row 7 then one to row 9.
    request(1'b0, 7, 1);
    drain();
    request(1'b0, 7, 2);
    drain();
    request(1'b0, 9, 3);
    drain();

    // Reset in the middle of a burst.
    request(1'b0, 11, 12);
    while (cyc < acc_cyc + TRCD + 2) step();
    n_rst = 1'b0;
    #1;
    chk("rst_cmd", cmd, CMD_NOP);
    chk("rst_cmd_row", cmd_row, 32'd0);
    chk("rst_cmd_col", cmd_col, 32'd0);
    chk("rst_beat_valid", beat_valid, 1'b0);
    chk("rst_beat_last", beat_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    q.delete();
    busy_hi = -1;
`ifdef DDR_OPEN_ROW_EN
    m_open = 1'b0;
`endif
    step();
    step();
    n_rst = 1'b1;
    request(1'b1, 13, 14);
    drain();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_scheduler.md
# ddr_cmd_scheduler

Sequences single-bank DDR transactions from one host request port into ACT / RD / WR / PRE commands and burst-beat strobes. The burst length comes from the 2-bit `burst_size` field held by the configuration register. The block sits between the host request interface and the DDR PHY command path, and consumes `burst_size` / `config_update` from the configuration register.

## Interface
- `ROW_W`, 14, row address width
- `COL_W`, 10, column address width
- `TRCD`, 3, ACT-to-RD/WR spacing in cycles; legal range 1..15
- `TRP`, 3, PRE-to-ACT/IDLE spacing in cycles; legal range 1..15

Ports:
- `clk` in 1: clock
- `n_rst` in 1: reset, asynchronous, active-low
- `burst_size` in 2: beats per burst = 1 << `burst_size` (1/2/4/8)
- `config_update` in 1: one-cycle pulse; the configuration was just rewritten
- `req_valid` in 1: host request present
- `req_write` in 1: 1 = write, 0 = read
- `req_row` in `ROW_W`: request row
- `req_col` in `COL_W`: request column
- `req_ready` out 1: request accepted when `req_valid` && `req_ready`
- `cmd` out 3: NOP=0, ACT=1, RD=2, WR=3, PRE=4
- `cmd_row` out `ROW_W`: valid with ACT; otherwise 0
- `cmd_col` out `COL_W`: valid with RD/WR; otherwise 0
- `beat_valid` out 1: data beat strobe
- `beat_last` out 1: final beat of the burst
- `busy` out 1: state != IDLE

## Operation
- FSM states: IDLE, ACT, TRCD_WAIT, RW, BURST, PRE, TRP_WAIT.
- `req_ready` = (state == IDLE) && !`config_update`. Requests are refused during a config-update cycle so that the new `burst_size` is always used.
- On acceptance, the block registers `req_write`, `req_row`, `req_col` and the beat count N = 1 << `burst_size`. Later changes to `burst_size` do not affect an in-flight burst.
- Transitions:
  - IDLE → ACT on accept.
  - ACT issues ACT for 1 cycle.
  - TRCD_WAIT holds NOP for TRCD-1 cycles and is skipped when TRCD = 1.
  - RW issues RD or WR for 1 cycle.
  - BURST asserts `beat_valid` for N cycles, with `beat_last` on the Nth.
  - PRE issues PRE for 1 cycle.
  - TRP_WAIT holds NOP for TRP-1 cycles, then returns to IDLE.
- Beat counter is 4 bits and counts N-1 down to 0. `beat_last` = `beat_valid` && count == 0.
- Outputs are registered. `cmd` = NOP in every cycle not listed above.
- `req_valid` held without acceptance: no effect. Host fields are sampled only on the accept cycle.
- Reset mid-operation aborts immediately:
  - state → IDLE, with no PRE issued;
  - any open row is forgotten.

## Timing
- Reset values:
  - `cmd` = NOP; `cmd_row`, `cmd_col`, `beat_valid`, `beat_last`, `busy` = 0.
  - `req_ready` = 1 (IDLE, `config_update` = 0).
- Cycle numbering: accept in cycle 0.
  - ACT in cycle 1.
  - RD/WR in cycle 1+TRCD.
  - Beats in cycles 2+TRCD .. 1+TRCD+N.
  - PRE in cycle 2+TRCD+N.
  - `req_ready` returns in cycle 2+TRCD+N+TRP.
- Back-to-back: the next accept can occur in the first cycle `req_ready` is high.

## Configuration
- `DDR_OPEN_ROW_EN` defined (open-page policy):
  - After BURST the FSM goes to IDLE without PRE. It keeps the open row and an `row_open` flag.
  - Next accept, same row: RW in cycle 1.
  - Next accept, different row: PRE in cycle 1, TRP_WAIT, then ACT, TRCD_WAIT, RW.
  - `config_update` while a row is open closes it: PRE is issued on the next IDLE cycle without a request, followed by TRP_WAIT.
- Not defined (closed-page policy): every burst is followed by PRE + TRP_WAIT, exactly as in Operation.

## Structure
- `ddr_pkg` holds:
  - `cmd_t` enum (NOP/ACT/RD/WR/PRE, 3 bits);
  - `sched_state_t` enum;
  - `localparam` `BEAT_CNT_W` = 4.
- Sub-module `ddr_delay_counter`: a loadable 4-bit down-counter with `load`, `value` and `done` outputs. It is shared by TRCD_WAIT and TRP_WAIT.

## Test plan
- Reset, then `burst_size` = 2, read row 5 col 8, TRCD = TRP = 3:
  - ACT row 5 at cycle 1; RD col 8 at cycle 4;
  - `beat_valid` cycles 5-8, `beat_last` at 8;
  - PRE at 9; `req_ready` high at 12.
- `burst_size` = 0, write: WR then exactly 1 beat with `beat_valid` and `beat_last` both high; `cmd` = WR (3).
- `burst_size` changed 2→3 mid-burst: current burst stays 4 beats; the next request gives 8 beats.
- `config_update` high with `req_valid` in IDLE: `req_ready` = 0 that cycle, accept happens in the next cycle, and N reflects the new size.
- `DDR_OPEN_ROW_EN`:
  - two reads to row 7: the second produces RD in cycle 1 with no ACT;
  - a third read to row 9 produces PRE, wait, ACT row 9.
- Assert `n_rst` during BURST:
  - all outputs reset immediately; `busy` = 0;
  - after release, a new request starts from ACT.
